// File: rtl/gpu_pkg.sv
// Shared geometry-stage definitions: default coordinate width and the
// midpoint sequencer state encoding.
package gpu_pkg;

   localparam int COORD_WIDTH = 10;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CX   = 3'd1;
   localparam logic [2:0] ST_CY   = 3'd2;
   localparam logic [2:0] ST_CZ   = 3'd3;
   localparam logic [2:0] ST_OUT  = 3'd4;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      CX   = ST_CX,
      CY   = ST_CY,
      CZ   = ST_CZ,
      OUT  = ST_OUT
   } state_t;

endpackage

// File: rtl/divide_by_two.sv
// Signed halving by arithmetic shift right, rounding toward minus infinity.
module divide_by_two #(
   parameter int WIDTH = 11
) (
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   assign dout = {din[WIDTH-1], din[WIDTH-1:1]};

endmodule

// File: rtl/midpoint_sequencer.sv
// Midpoint of two signed vertices, one component per cycle through a single
// shared adder and halver, with valid/ready handshakes on both sides.
module midpoint_sequencer
   import gpu_pkg::*;
#(
   parameter int WIDTH = COORD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] ax,
   input  logic [WIDTH-1:0] ay,
   input  logic [WIDTH-1:0] az,
   input  logic [WIDTH-1:0] bx,
   input  logic [WIDTH-1:0] by,
   input  logic [WIDTH-1:0] bz,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] mx,
   output logic [WIDTH-1:0] my,
   output logic [WIDTH-1:0] mz,
   output logic             busy
);

   state_t state, next_state;

   logic [WIDTH-1:0] a_x, a_y, a_z, b_x, b_y, b_z;
   logic [WIDTH-1:0] a_sel, b_sel;
   logic [WIDTH:0]   sum, halved;
   logic             accept;
   logic             halved_msb_unused;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state  = state;
      start_ready = 1'b0;
      m_valid     = 1'b0;
      busy        = 1'b1;
      case (state)
         IDLE: begin
            start_ready = 1'b1;
            busy        = 1'b0;
            if (start_valid) next_state = CX;
         end
         CX:  next_state = CY;
         CY:  next_state = CZ;
         CZ:  next_state = OUT;
         OUT: begin
            m_valid     = 1'b1;
            start_ready = m_ready;
            if (m_ready) next_state = start_valid ? CX : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign accept = start_valid & start_ready;

   always_comb begin
      a_sel = a_x;
      b_sel = b_x;
      case (state)
         CY: begin
            a_sel = a_y;
            b_sel = b_y;
         end
         CZ: begin
            a_sel = a_z;
            b_sel = b_z;
         end
         default: ;
      endcase
   end

   // One extra bit keeps the sum exact for any pair of WIDTH-bit operands.
   assign sum = {a_sel[WIDTH-1], a_sel} + {b_sel[WIDTH-1], b_sel};

   divide_by_two #(.WIDTH(WIDTH + 1)) u_halve (
      .din  (sum),
      .dout (halved)
   );

   // The halved sum always fits in WIDTH bits, so its top bit is a copy of the sign.
   assign halved_msb_unused = halved[WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_x <= '0;
         a_y <= '0;
         a_z <= '0;
         b_x <= '0;
         b_y <= '0;
         b_z <= '0;
         mx  <= '0;
         my  <= '0;
         mz  <= '0;
      end else begin
         if (accept) begin
            a_x <= ax;
            a_y <= ay;
            a_z <= az;
            b_x <= bx;
            b_y <= by;
            b_z <= bz;
         end
         case (state)
            CX:      mx <= halved[WIDTH-1:0];
            CY:      my <= halved[WIDTH-1:0];
            CZ:      mz <= halved[WIDTH-1:0];
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_midpoint_sequencer.sv
// Directed bench for midpoint_sequencer: expected midpoints are queued when
// operands are offered and compared when m_valid appears.
module tb_midpoint_sequencer;

   localparam int W = 10;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] ax, ay, az, bx, by, bz;
   logic         m_valid;
   logic         m_ready;
   logic [W-1:0] mx, my, mz;
   logic         busy;

   typedef struct {
      int x;
      int y;
      int z;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp;
   int   n_vec = 0;
   int   n_miss = 0;
   int   cyc = 0;
   int   accept_cyc = 0;

   midpoint_sequencer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .ax          (ax),
      .ay          (ay),
      .az          (az),
      .bx          (bx),
      .by          (by),
      .bz          (bz),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .mx          (mx),
      .my          (my),
      .mz          (mz),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int sx(input logic [W-1:0] v);
      return int'($signed(v));
   endfunction

   // Floor of (a+b)/2 done with integer division, independent of any shifting.
   function automatic int mid(input int a, input int b);
      int s;
      s = a + b;
      if (s >= 0) return s / 2;
      return -((-s + 1) / 2);
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      n_vec++;
      assert (observed === expected) else begin
         n_miss++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Offers operands now and returns just after the accepting edge.
   task automatic applyStimulus(input int xa, input int ya, input int za,
                                input int xb, input int yb, input int zb);
      int tries;
      exp_t e;
      start_valid = 1'b1;
      ax = xa[W-1:0];
      ay = ya[W-1:0];
      az = za[W-1:0];
      bx = xb[W-1:0];
      by = yb[W-1:0];
      bz = zb[W-1:0];
      e.x = mid(xa, xb);
      e.y = mid(ya, yb);
      e.z = mid(za, zb);
      sb.push_back(e);
      tries = 0;
      #1;
      while (!start_ready && tries < 20) begin
         @(negedge clk);
         #1;
         tries++;
      end
      if (!start_ready) begin
         checkOutput("accept_timeout", 0, 1);
         start_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      accept_cyc  = cyc;
      start_valid = 1'b0;
   endtask

   task automatic waitResult(input string tag);
      int k;
      k = 0;
      while (k < 30) begin
         @(negedge clk);
         k++;
         if (m_valid) break;
      end
      if (!m_valid) begin
         checkOutput({tag, "_timeout"}, 0, 1);
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      checkOutput({tag, "_latency_edges"}, cyc - accept_cyc, 3);
      if (sb.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 0, 1);
         return;
      end
      last_exp = sb.pop_front();
      checkOutput({tag, "_mx"}, sx(mx), last_exp.x);
      checkOutput({tag, "_my"}, sx(my), last_exp.y);
      checkOutput({tag, "_mz"}, sx(mz), last_exp.z);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_start_ready"}, int'(start_ready), 1);
      checkOutput({tag, "_m_valid"}, int'(m_valid), 0);
      checkOutput({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      int seen;
      rst = 1'b1;
      start_valid = 1'b0;
      m_ready = 1'b1;
      {ax, ay, az, bx, by, bz} = '0;
      repeat (2) @(negedge clk);

      checkIdle("reset");
      checkOutput("reset_mx", sx(mx), 0);
      checkOutput("reset_my", sx(my), 0);
      checkOutput("reset_mz", sx(mz), 0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] basic midpoint");
      applyStimulus(10, 20, -30, 4, -8, 30);
      waitResult("basic");
      @(negedge clk);
      checkIdle("after_basic");

      $display("[TB] extremes then back-to-back rounding");
      applyStimulus(511, -512, 511, 511, -512, -512);
      waitResult("extremes");
      applyStimulus(3, -3, -1, 0, 0, 0);
      waitResult("rounding");
      @(negedge clk);
      checkIdle("after_rounding");

      $display("[TB] backpressure");
      m_ready = 1'b0;
      applyStimulus(100, -7, -100, -50, 8, -101);
      waitResult("bp");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("bp_hold_m_valid", int'(m_valid), 1);
         checkOutput("bp_hold_start_ready", int'(start_ready), 0);
         checkOutput("bp_hold_mx", sx(mx), last_exp.x);
         checkOutput("bp_hold_mz", sx(mz), last_exp.z);
      end
      m_ready = 1'b1;
      applyStimulus(-1, 1, 200, -2, 2, 201);
      waitResult("bp_next");

      $display("[TB] reset during CY");
      @(negedge clk);
      applyStimulus(50, 60, 70, 50, 60, 70);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      void'(sb.pop_front());
      checkIdle("mid_reset");
      checkOutput("mid_reset_mx", sx(mx), 0);
      checkOutput("mid_reset_my", sx(my), 0);
      checkOutput("mid_reset_mz", sx(mz), 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (m_valid) seen = 1;
      end
      checkOutput("no_m_valid_after_reset", seen, 0);
      applyStimulus(-100, 33, 8, -101, 34, -9);
      waitResult("post_reset");
      @(negedge clk);

      $display("[TB] start_valid pulsed during CX");
      applyStimulus(40, -40, 7, 2, -2, 8);
      start_valid = 1'b1;
      ax = 10'sd300;
      ay = 10'sd300;
      az = 10'sd300;
      bx = -10'sd300;
      by = -10'sd300;
      bz = -10'sd300;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      waitResult("pulse_cx");
      @(negedge clk);
      checkIdle("after_pulse");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
